// File: rtl/if_id_queue.sv
// IF/ID instruction queue: DEPTH-entry FIFO of pc/inst pairs between fetch and decode.
// Optional empty-queue bypass (same-cycle fetch-to-decode) is enabled by defining IF_ID_BYPASS_EN.
module if_id_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] NOP_INST = 32'h00000013
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_pc,
   input  logic [31:0]                in_inst,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_pc,
   output logic [31:0]                out_inst,
   input  logic                       flush,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FullCnt = DEPTH[AW:0];

   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [31:0]   pc_mem_q   [DEPTH];
   logic [31:0]   pc_mem_d   [DEPTH];
   logic [31:0]   inst_mem_q [DEPTH];
   logic [31:0]   inst_mem_d [DEPTH];

   logic bypass;
   logic is_empty;
   logic push;
   logic pop_mem;

   assign is_empty = (count_q == '0);

   // Bypass only applies to an empty queue; with the macro undefined it is tied off.
   always_comb begin
      bypass = 1'b0;
`ifdef IF_ID_BYPASS_EN
      bypass = is_empty && in_valid && !flush;
`endif
   end

   always_comb begin
      in_ready  = (count_q != FullCnt);
      out_valid = (!is_empty || bypass) && !flush;
      out_pc    = 32'h0;
      out_inst  = NOP_INST;
      if (bypass) begin
         out_pc   = in_pc;
         out_inst = in_inst;
      end else if (!is_empty) begin
         out_pc   = pc_mem_q[rd_ptr_q];
         out_inst = inst_mem_q[rd_ptr_q];
      end
      count = count_q;
   end

   // A bypassed entry that decode takes immediately is never written.
   assign push    = in_valid && in_ready && !flush && !(bypass && out_ready);
   assign pop_mem = !is_empty && out_ready && !flush;

   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      pc_mem_d   = pc_mem_q;
      inst_mem_d = inst_mem_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            pc_mem_d[wr_ptr_q]   = in_pc;
            inst_mem_d[wr_ptr_q] = in_inst;
            wr_ptr_d             = wr_ptr_q + 1'b1;
         end
         if (pop_mem) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         if (push && !pop_mem) begin
            count_d = count_q + 1'b1;
         end else if (!push && pop_mem) begin
            count_d = count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; validity is tracked by count alone.
   always_ff @(posedge clk) begin
      pc_mem_q   <= pc_mem_d;
      inst_mem_q <= inst_mem_d;
   end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (DEPTH=4); bypass expectations follow IF_ID_BYPASS_EN.
module tb_if_id_queue;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_inst;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        flush;
   logic [2:0]  count;

   int errors = 0;
   int checks = 0;

   if_id_queue #(
      .DEPTH    (4),
      .NOP_INST (32'h00000013)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pc     (in_pc),
      .in_inst   (in_inst),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_inst  (out_inst),
      .flush     (flush),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return 32'hA000_0000 | pc;
   endfunction

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_pc     = 32'h0;
      in_inst   = 32'h0;
      out_ready = 1'b0;
      flush     = 1'b0;

      // Reset state, checked before any clock edge.
      #3;
      check("rst_count", 32'(count), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_pc", out_pc, 32'h0);
      check("rst_out_inst", out_inst, 32'h00000013);
      #9;
      rst_n = 1'b1;

      // Fill with out_ready low; first push lands on the first edge after reset release.
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_pc   = 32'(i * 4);
         in_inst = inst_of(32'(i * 4));
         tick();
         if (i == 0) begin
            check("first_push_count", 32'(count), 32'd1);
            check("first_push_valid", 32'(out_valid), 32'd1);
            check("first_push_pc", out_pc, 32'h0);
         end
      end
      check("full_count", 32'(count), 32'd4);
      check("full_in_ready", 32'(in_ready), 32'd0);
      in_pc   = 32'h10;
      in_inst = inst_of(32'h10);
      tick();
      check("refused_count", 32'(count), 32'd4);
      check("refused_head", out_pc, 32'h0);

      // Drain in order.
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain_pc", out_pc, 32'(i * 4));
         check("drain_inst", out_inst, inst_of(32'(i * 4)));
         tick();
      end
      check("drained_count", 32'(count), 32'd0);
      check("drained_valid", 32'(out_valid), 32'd0);
      check("drained_inst", out_inst, 32'h00000013);
      check("drained_pc", out_pc, 32'h0);

      // Full queue refuses a push even while popping.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_pc   = 32'h100 + 32'(i * 4);
         in_inst = inst_of(in_pc);
         tick();
      end
      in_pc     = 32'h50;
      in_inst   = inst_of(32'h50);
      out_ready = 1'b1;
      check("full_pop_in_ready", 32'(in_ready), 32'd0);
      tick();
      check("full_pop_count", 32'(count), 32'd3);
      in_valid = 1'b0;
      for (int i = 1; i < 4; i++) begin
         check("full_pop_order", out_pc, 32'h100 + 32'(i * 4));
         tick();
      end
      check("full_pop_empty", 32'(count), 32'd0);

      // Steady state push+pop at count=2, pointers wrap.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 2; i++) begin
         in_pc   = 32'h200 + 32'(i * 4);
         in_inst = inst_of(in_pc);
         tick();
      end
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         in_pc   = 32'h208 + 32'(k * 4);
         in_inst = inst_of(in_pc);
         check("stream_head", out_pc, 32'h200 + 32'(k * 4));
         tick();
         check("stream_count", 32'(count), 32'd2);
      end

      // Flush with count=3 and a simultaneous push offer.
      out_ready = 1'b0;
      in_pc     = 32'h300;
      in_inst   = inst_of(32'h300);
      tick();
      check("pre_flush_count", 32'(count), 32'd3);
      check("pre_flush_head", out_pc, 32'h228);
      flush   = 1'b1;
      in_pc   = 32'h40;
      in_inst = inst_of(32'h40);
      #1;
      check("flush_out_valid", 32'(out_valid), 32'd0);
      check("flush_in_ready", 32'(in_ready), 32'd1);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      #1;
      check("post_flush_count", 32'(count), 32'd0);
      check("post_flush_valid", 32'(out_valid), 32'd0);
      in_valid = 1'b1;
      in_pc    = 32'h44;
      in_inst  = inst_of(32'h44);
      tick();
      in_valid = 1'b0;
      check("post_flush_push_count", 32'(count), 32'd1);
      check("post_flush_head", out_pc, 32'h44);
      out_ready = 1'b1;
      tick();
      check("post_flush_drain", 32'(count), 32'd0);

      // Flush on an empty queue.
      out_ready = 1'b0;
      flush     = 1'b1;
      tick();
      flush = 1'b0;
      check("empty_flush_count", 32'(count), 32'd0);
      check("empty_flush_ready", 32'(in_ready), 32'd1);

      // Asynchronous reset mid-cycle with two entries held.
      in_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         in_pc   = 32'h500 + 32'(i * 4);
         in_inst = inst_of(in_pc);
         tick();
      end
      in_valid = 1'b0;
      check("pre_areset_count", 32'(count), 32'd2);
      #1;
      rst_n = 1'b0;
      #1;
      check("areset_count", 32'(count), 32'd0);
      check("areset_valid", 32'(out_valid), 32'd0);
      check("areset_ready", 32'(in_ready), 32'd1);
      check("areset_inst", out_inst, 32'h00000013);
      rst_n = 1'b1;
      tick();
      check("areset_stays_empty", 32'(count), 32'd0);

      // Empty queue with fetch and decode both ready.
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_pc     = 32'h80;
      in_inst   = inst_of(32'h80);
      #1;
`ifdef IF_ID_BYPASS_EN
      check("bypass_valid", 32'(out_valid), 32'd1);
      check("bypass_pc", out_pc, 32'h80);
      check("bypass_inst", out_inst, inst_of(32'h80));
      tick();
      in_valid = 1'b0;
      #1;
      check("bypass_count", 32'(count), 32'd0);
      check("bypass_after_valid", 32'(out_valid), 32'd0);
`else
      check("nobypass_valid", 32'(out_valid), 32'd0);
      check("nobypass_pc", out_pc, 32'h0);
      tick();
      in_valid = 1'b0;
      #1;
      check("nobypass_count", 32'(count), 32'd1);
      check("nobypass_late_valid", 32'(out_valid), 32'd1);
      check("nobypass_late_pc", out_pc, 32'h80);
      tick();
      check("nobypass_drained", 32'(count), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
